// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory opcodes, FSM states, byte-lane
// constants and small opcode-decoding helpers used by the stage and its aligner.
package mem_pkg;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Byte accesses are always aligned; halfwords need lane bit 0 clear, words both bits.
  function automatic logic addr_ok(input logic [7:0] op, input logic [1:0] lane);
    logic ok;
    ok = 1'b1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) ok = ~lane[0];
    else if (op inside {OP_LW, OP_SW}) ok = (lane == 2'b00);
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [7:0] op, input logic [1:0] lane);
    logic [3:0] be;
    be = BE_ALL;
    if (op == OP_SB) be = BE_BYTE0 << lane;
    else if (op == OP_SH) be = lane[1] ? BE_HI_HALF : BE_LO_HALF;
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] data);
    logic [31:0] wdata;
    wdata = data;
    if (op == OP_SB) wdata = {4{data[7:0]}};
    else if (op == OP_SH) wdata = {2{data[15:0]}};
    return wdata;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    value   = '0;
    case (op)
      OP_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  value = {24'd0, shifted[7:0]};
      OP_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  value = {16'd0, shifted[15:0]};
      OP_LW:   value = rdata;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues loads/stores over a req/ack port, stalls upstream while
// an access is outstanding and registers the writeback bundle for MEM/WB.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] reg_operValue_i,
  input  logic [4:0]  write_regAddress_i,
  input  logic        is_write_i,
  input  logic [31:0] write_regValue_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_req_o,
  output logic        addr_err_o,
  output logic [4:0]  write_regAddress_o,
  output logic        is_write_o,
  output logic [31:0] write_regValue_o
);

  state_t      state;
  logic [7:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] load_value;
  logic        is_mem;
  logic        aligned;
  logic        start;

  assign is_mem  = is_load_op(aluop_i) | is_store_op(aluop_i);
  assign aligned = addr_ok(aluop_i, mem_address_i[1:0]);
  assign start   = (state == IDLE) && is_mem && aligned;

  // Released in the ack cycle so upstream advances on the same edge the access retires.
  assign stall_req_o = start || ((state == WAIT) && !dmem_ack_i);

  load_align u_load_align (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (dmem_rdata_i),
    .value (load_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      op_q               <= '0;
      lane_q             <= '0;
      rd_q               <= '0;
      we_q               <= 1'b0;
      dmem_req_o         <= 1'b0;
      dmem_we_o          <= 1'b0;
      dmem_addr_o        <= '0;
      dmem_be_o          <= BE_NONE;
      dmem_wdata_o       <= '0;
      addr_err_o         <= 1'b0;
      write_regAddress_o <= '0;
      is_write_o         <= 1'b0;
      write_regValue_o   <= '0;
    end else begin
      addr_err_o <= 1'b0;
      case (state)
        IDLE: begin
          write_regAddress_o <= write_regAddress_i;
          if (start) begin
            op_q             <= aluop_i;
            lane_q           <= mem_address_i[1:0];
            rd_q             <= write_regAddress_i;
            we_q             <= is_write_i;
            dmem_req_o       <= 1'b1;
            dmem_we_o        <= is_store_op(aluop_i);
            dmem_addr_o      <= {mem_address_i[31:2], 2'b00};
            dmem_be_o        <= is_store_op(aluop_i) ? store_be(aluop_i, mem_address_i[1:0]) : BE_ALL;
            dmem_wdata_o     <= is_store_op(aluop_i) ? store_wdata(aluop_i, reg_operValue_i) : '0;
            is_write_o       <= 1'b0;
            write_regValue_o <= '0;
            state            <= WAIT;
          end else if (is_mem) begin
            is_write_o       <= 1'b0;
            write_regValue_o <= '0;
            addr_err_o       <= 1'b1;
          end else begin
            is_write_o       <= is_write_i;
            write_regValue_o <= write_regValue_i;
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            dmem_req_o         <= 1'b0;
            dmem_we_o          <= 1'b0;
            dmem_addr_o        <= '0;
            dmem_be_o          <= BE_NONE;
            dmem_wdata_o       <= '0;
            write_regAddress_o <= rd_q;
            is_write_o         <= is_load_op(op_q) & we_q;
            write_regValue_o   <= is_load_op(op_q) ? load_value : '0;
            state              <= IDLE;
          end else begin
            is_write_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a small word memory answers requests after a
// chosen number of wait cycles; results are compared against hand-computed values.
module tb_mem_access_stage;

  localparam logic [7:0] NOP = 8'b00100001;
  localparam logic [7:0] LB  = 8'b11100000;
  localparam logic [7:0] LH  = 8'b11100001;
  localparam logic [7:0] LW  = 8'b11100011;
  localparam logic [7:0] LBU = 8'b11100100;
  localparam logic [7:0] LHU = 8'b11100101;
  localparam logic [7:0] SH  = 8'b11101001;
  localparam logic [7:0] SW  = 8'b11101011;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  aluop_i;
  logic [31:0] mem_address_i;
  logic [31:0] reg_operValue_i;
  logic [4:0]  write_regAddress_i;
  logic        is_write_i;
  logic [31:0] write_regValue_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_req_o;
  logic        addr_err_o;
  logic [4:0]  write_regAddress_o;
  logic        is_write_o;
  logic [31:0] write_regValue_o;

  logic [31:0] mem_model [0:255];
  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk                (clk),
    .reset              (reset),
    .aluop_i            (aluop_i),
    .mem_address_i      (mem_address_i),
    .reg_operValue_i    (reg_operValue_i),
    .write_regAddress_i (write_regAddress_i),
    .is_write_i         (is_write_i),
    .write_regValue_i   (write_regValue_i),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_be_o          (dmem_be_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_ack_i         (dmem_ack_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .stall_req_o        (stall_req_o),
    .addr_err_o         (addr_err_o),
    .write_regAddress_o (write_regAddress_o),
    .is_write_o         (is_write_o),
    .write_regValue_o   (write_regValue_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] rd, input logic we, input logic [31:0] value);
    aluop_i            = op;
    mem_address_i      = addr;
    reg_operValue_i    = data;
    write_regAddress_i = rd;
    is_write_i         = we;
    write_regValue_i   = value;
  endtask

  // Called at a negedge; returns at the negedge after the ack edge with inputs still held.
  task automatic memAccess(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd, input logic we, input int lat,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic exp_dwe,
                           input logic [31:0] exp_val, input logic exp_wbwe);
    int stalls;
    stalls = 0;
    applyStimulus(op, addr, data, rd, we, 32'h0);
    #1;
    checkOutput({tag, " req_idle"}, 32'(dmem_req_o), 32'd0);
    if (stall_req_o) stalls++;
    @(negedge clk);
    checkOutput({tag, " req"}, 32'(dmem_req_o), 32'd1);
    checkOutput({tag, " addr"}, dmem_addr_o, exp_addr);
    checkOutput({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
    checkOutput({tag, " wdata"}, dmem_wdata_o, exp_wdata);
    checkOutput({tag, " dwe"}, 32'(dmem_we_o), 32'(exp_dwe));
    checkOutput({tag, " bubble"}, 32'(is_write_o), 32'd0);
    for (int w = 0; w <= lat; w++) begin
      if (w == lat) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = mem_model[dmem_addr_o[9:2]];
        if (dmem_we_o)
          for (int k = 0; k < 4; k++)
            if (dmem_be_o[k]) mem_model[dmem_addr_o[9:2]][8*k +: 8] = dmem_wdata_o[8*k +: 8];
      end
      #1;
      if (stall_req_o) stalls++;
      @(negedge clk);
      dmem_ack_i = 1'b0;
    end
    checkOutput({tag, " stall_cycles"}, 32'(stalls), 32'(lat + 1));
    checkOutput({tag, " req_drop"}, 32'(dmem_req_o), 32'd0);
    checkOutput({tag, " wb_rd"}, 32'(write_regAddress_o), 32'(rd));
    checkOutput({tag, " wb_we"}, 32'(is_write_o), 32'(exp_wbwe));
    checkOutput({tag, " wb_val"}, write_regValue_o, exp_val);
  endtask

  initial begin
    reset        = 1'b1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    applyStimulus(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst stall", 32'(stall_req_o), 32'd0);
    checkOutput("rst req", 32'(dmem_req_o), 32'd0);
    checkOutput("rst wb_we", 32'(is_write_o), 32'd0);
    checkOutput("rst wb_val", write_regValue_o, 32'h0);
    checkOutput("rst err", 32'(addr_err_o), 32'd0);
    reset = 1'b0;

    applyStimulus(NOP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h12345678);
    #1;
    checkOutput("nop stall", 32'(stall_req_o), 32'd0);
    checkOutput("nop req", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    checkOutput("nop wb_rd", 32'(write_regAddress_o), 32'd5);
    checkOutput("nop wb_we", 32'(is_write_o), 32'd1);
    checkOutput("nop wb_val", write_regValue_o, 32'h12345678);

    mem_model[0] = 32'h80FF0011;
    memAccess("lb", LB, 32'h1003, 32'h0, 5'd7, 1'b1, 3, 32'h1000, 4'b1111, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1);
    memAccess("lbu", LBU, 32'h1003, 32'h0, 5'd7, 1'b1, 3, 32'h1000, 4'b1111, 32'h0, 1'b0, 32'h00000080, 1'b1);
    memAccess("lh_hi", LH, 32'h1002, 32'h0, 5'd8, 1'b1, 1, 32'h1000, 4'b1111, 32'h0, 1'b0, 32'hFFFF80FF, 1'b1);
    memAccess("lhu_hi", LHU, 32'h1002, 32'h0, 5'd8, 1'b1, 0, 32'h1000, 4'b1111, 32'h0, 1'b0, 32'h000080FF, 1'b1);
    memAccess("lh_lo", LH, 32'h1000, 32'h0, 5'd8, 1'b1, 2, 32'h1000, 4'b1111, 32'h0, 1'b0, 32'h00000011, 1'b1);
    memAccess("sh", SH, 32'h2002, 32'hAAAA5678, 5'd3, 1'b1, 0, 32'h2000, 4'b1100, 32'h56785678, 1'b1, 32'h0, 1'b0);
    memAccess("lw_after_sh", LW, 32'h2000, 32'h0, 5'd4, 1'b1, 0, 32'h2000, 4'b1111, 32'h0, 1'b0, 32'h56780011, 1'b1);
    applyStimulus(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);

    applyStimulus(LW, 32'h3001, 32'h0, 5'd4, 1'b1, 32'h0);
    #1;
    checkOutput("mis stall", 32'(stall_req_o), 32'd0);
    checkOutput("mis req_comb", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    checkOutput("mis err", 32'(addr_err_o), 32'd1);
    checkOutput("mis wb_we", 32'(is_write_o), 32'd0);
    checkOutput("mis wb_val", write_regValue_o, 32'h0);
    checkOutput("mis req", 32'(dmem_req_o), 32'd0);
    applyStimulus(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("mis err_pulse", 32'(addr_err_o), 32'd0);

    // Abort an outstanding load with reset, then rerun it cleanly.
    applyStimulus(LW, 32'h3000, 32'h0, 5'd9, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("rstwait req", 32'(dmem_req_o), 32'd1);
    reset = 1'b1;
    applyStimulus(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstwait req_after", 32'(dmem_req_o), 32'd0);
    checkOutput("rstwait stall", 32'(stall_req_o), 32'd0);
    checkOutput("rstwait addr", dmem_addr_o, 32'h0);
    checkOutput("rstwait be", 32'(dmem_be_o), 32'd0);
    checkOutput("rstwait wb_we", 32'(is_write_o), 32'd0);
    mem_model[0] = 32'h13572468;
    memAccess("lw_post_rst", LW, 32'h3000, 32'h0, 5'd9, 1'b1, 1, 32'h3000, 4'b1111, 32'h0, 1'b0, 32'h13572468, 1'b1);

    memAccess("sw_b2b", SW, 32'h40, 32'hCAFEF00D, 5'd2, 1'b0, 0, 32'h40, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
    memAccess("lw_b2b", LW, 32'h40, 32'h0, 5'd10, 1'b1, 0, 32'h40, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    applyStimulus(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("final stall", 32'(stall_req_o), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage for the five-stage MIPS core: takes the execute stage's result bundle (ALU op, effective address, store data, destination register, write enable, ALU result), performs loads and stores over a req/ack data-memory port, and delivers a registered writeback bundle to MEM/WB. It stalls the upstream pipeline for the duration of any memory access and flags misaligned accesses.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- aluop_i  in  8  operation code from execute
- mem_address_i  in  32  effective address
- reg_operValue_i  in  32  store data (rt value)
- write_regAddress_i  in  5  destination register
- is_write_i  in  1  destination write enable
- write_regValue_i  in  32  ALU/link result for non-load ops
- dmem_req_o  out  1  memory request, held until ack
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_addr_o  out  32  word address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  request complete; rdata valid this cycle for loads
- dmem_rdata_i  in  32  load word
- stall_req_o  out  1  combinational; upstream holds all inputs while 1
- addr_err_o  out  1  one-cycle pulse, misaligned access
- write_regAddress_o  out  5  registered writeback address
- is_write_o  out  1  registered writeback enable
- write_regValue_o  out  32  registered writeback value

## Operation
- Opcodes: LB 8'b11100000, LH 8'b11100001, LW 8'b11100011, LBU 8'b11100100, LHU 8'b11100101, SB 8'b11101000, SH 8'b11101001, SW 8'b11101011; all other codes are non-memory.
- Byte lanes little-endian: lane k = data[8k+7:8k], k = addr[1:0].
- Alignment: halfword requires addr[0]=0, word requires addr[1:0]=0.
- FSM states IDLE, WAIT.
- IDLE, non-memory op: next edge loads writeback regs with inputs unchanged; stays IDLE.
- IDLE, misaligned memory op: no request, no stall; next edge is_write_o=0, addr_err_o=1, value 0.
- IDLE, aligned memory op: stall_req_o=1; next edge captures op/address/data into hold regs, drives dmem_* from them, writeback is_write_o=0 (bubble), -> WAIT.
- WAIT: dmem_req_o=1, dmem_* stable; stall_req_o = ~dmem_ack_i; is_write_o=0 each non-ack edge.
- WAIT + ack: edge loads writeback regs (load: extended data, is_write_o=is_write_i; store: is_write_o=0), -> IDLE, req drops.
- Load extract: LB/LH sign-extend, LBU/LHU zero-extend the selected lane(s); LW whole word.
- Store: SB be=1<<k, wdata={4{byte}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{half}}; SW be=4'b1111.
- Loads: dmem_we_o=0, dmem_be_o=4'b1111, dmem_wdata_o=0.
- dmem_ack_i in IDLE ignored.

## Timing
- Reset: state IDLE; all outputs 0, including stall_req_o and dmem_req_o.
- Reset mid-WAIT: request abandoned, outputs 0 next edge; memory tolerates dropped req.
- Non-memory latency 1 cycle; memory latency 2 + wait cycles (ack in first WAIT cycle gives 2).
- stall_req_o depends only on state, aluop_i, mem_address_i[1:0], dmem_ack_i; no path from dmem_rdata_i.
- Writeback outputs and dmem_* are registered.

## Structure
- Shared package mem_pkg: the eight opcode constants, state enum, byte-lane helper constants.
- One sub-module: load_align (combinational; op, addr[1:0], rdata -> 32-bit extended value).

## Test plan
- Non-memory: aluop 8'b00100001, value 32'h12345678, rd 5, we 1 -> next cycle wb=(5,1,32'h12345678), no stall, no req.
- LB addr 32'h1003, rdata 32'h80FF0011, ack after 3 WAIT cycles -> dmem_addr 32'h1000, stall 4 cycles, wb value 32'hFFFFFF80; LBU same -> 32'h00000080.
- SH addr 32'h2002, data 32'hAAAA5678, ack immediate -> be 4'b1100, wdata 32'h56785678, we 1, is_write_o 0, stall 1 cycle.
- LW addr 32'h3001 -> no req, no stall, addr_err_o pulse, is_write_o 0.
- Reset asserted in WAIT -> next edge req 0, stall 0, all outputs 0; following LW completes normally.
- Back-to-back SW then LW to same word with ack latency 0 -> correct sequencing, LW returns stored value, no dropped instruction.
